lfsr_encrypter: RTL and testbench



---
 rtl/lfsr_encrypter.sv | 95 +++++++++
 tb/tb_lfsr_encrypter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/lfsr_encrypter.sv
// lfsr_encrypter: reads plaintext, prepends a 0x5f preamble, XORs with a 6-bit LFSR stream and writes a 64-byte ciphertext block.
// Optional ENC_ASCII_FILTER_EN replaces non-printable message bytes with 0x20 before encryption.
module lfsr_encrypter #(
  parameter int MSG_BASE = 0,
  parameter int CT_BASE  = 64,
  parameter int BLK_LEN  = 64,
  parameter int PRE_MIN  = 7,
  parameter int PRE_MAX  = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] tap_sel,
  input  logic [5:0] seed,
  input  logic [7:0] pre_len,
  output logic [7:0] raddr,
  input  logic [7:0] rdata,
  output logic       wr_en,
  output logic [7:0] waddr,
  output logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       err
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [5:0] lfsr, taps, seed_q;
  logic [2:0] tap_q;
  logic [7:0] pre_q, msg, pt;
  logic [6:0] idx, pl;
  logic idle_like, legal, accept, run, last;
  assign idle_like = (state == IDLE) || (state == DONE);
  assign legal     = (seed != 6'd0) && (tap_sel <= 3'd5);
  assign accept    = idle_like && start && legal;
  assign run       = state == RUN;
  assign last      = idx == 7'(BLK_LEN - 1);
`ifdef ENC_ASCII_FILTER_EN
  assign msg = (rdata[7] || rdata < 8'h20) ? 8'h20 : rdata;
`else
  assign msg = rdata;
`endif
  always_comb begin
    state_nx = state;
    wr_en    = 1'b0;
    raddr    = 8'(MSG_BASE);
    waddr    = 8'h00;
    wdata    = 8'h00;
    pt       = 8'h00;
    busy     = (state == LOAD) || run;
    state_nx = accept ? LOAD : (state == LOAD) ? RUN : (run && last) ? DONE : state;
    if (run) begin
      wr_en = 1'b1;
      waddr = 8'(CT_BASE) + {1'b0, idx};
      raddr = (idx >= pl) ? 8'(MSG_BASE) + {1'b0, idx - pl} : 8'(MSG_BASE);
      pt    = (idx < pl) ? 8'h5f : msg;
      wdata = pt ^ {2'b00, lfsr};
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr   <= 6'd0;
      taps   <= 6'd0;
      seed_q <= 6'd0;
      tap_q  <= 3'd0;
      pre_q  <= 8'd0;
      idx    <= 7'd0;
      pl     <= 7'd0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      err  <= idle_like && start && !legal;
      done <= (state == DONE) && !accept;
      if (accept) begin
        seed_q <= seed;
        tap_q  <= tap_sel;
        pre_q  <= pre_len;
      end
      if (state == LOAD) begin
        lfsr <= seed_q;
        idx  <= 7'd0;
        pl   <= (pre_q < 8'(PRE_MIN)) ? 7'(PRE_MIN) : (pre_q > 8'(PRE_MAX)) ? 7'(PRE_MAX) : pre_q[6:0];
        taps <= (tap_q == 3'd0) ? 6'h21 : (tap_q == 3'd1) ? 6'h2d : (tap_q == 3'd2) ? 6'h30 :
                (tap_q == 3'd3) ? 6'h33 : (tap_q == 3'd4) ? 6'h36 : 6'h39;
      end
      if (run) begin
        lfsr <= {lfsr[4:0], ^(lfsr & taps)};
        idx  <= idx + 7'd1;
      end
    end
  end
endmodule

// File: tb/tb_lfsr_encrypter.sv
// tb_lfsr_encrypter: randomized self-checking bench for lfsr_encrypter against a keystream/memory reference model.
module tb_lfsr_encrypter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] tap_sel = 3'd0;
  logic [5:0] seed = 6'd0;
  logic [7:0] pre_len = 8'd0;
  logic [7:0] raddr, rdata, waddr, wdata;
  logic       wr_en, busy, done, err;
  logic [7:0] mem [0:255];
  logic [7:0] exp_ct [0:63];
  logic [5:0] key [0:63];
  int         exp_pl;
  int         n_checks = 0;
  int         n_fail = 0;
  int         wr_count = 0;
  logic [5:0] tap_tab [0:5] = '{6'h21, 6'h2d, 6'h30, 6'h33, 6'h36, 6'h39};
  logic [7:0] hello [0:4] = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f};

  lfsr_encrypter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tap_sel(tap_sel), .seed(seed),
    .pre_len(pre_len), .raddr(raddr), .rdata(rdata), .wr_en(wr_en), .waddr(waddr),
    .wdata(wdata), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  assign rdata = mem[raddr];
  always @(posedge clk) if (wr_en) begin
    mem[waddr] <= wdata;
    wr_count <= wr_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] filt(input logic [7:0] b);
`ifdef ENC_ASCII_FILTER_EN
    return (b >= 8'h80 || b < 8'h20) ? 8'h20 : b;
`else
    return b;
`endif
  endfunction

  task automatic build_model(input logic [5:0] s, input logic [2:0] t, input logic [7:0] p);
    int l, tm;
    exp_pl = (p < 7) ? 7 : (p > 12) ? 12 : int'(p);
    l = int'(s);
    tm = int'(tap_tab[t]);
    for (int i = 0; i < 64; i++) begin
      key[i] = 6'(l);
      l = ((l * 2) % 64) + ($countones(l & tm) % 2);
    end
    for (int i = 0; i < 64; i++)
      exp_ct[i] = ((i < exp_pl) ? 8'h5f : filt(mem[i - exp_pl])) ^ {2'b00, key[i]};
  endtask

  task automatic issue_start(input logic [5:0] s, input logic [2:0] t, input logic [7:0] p);
    @(negedge clk);
    seed = s; tap_sel = t; pre_len = p; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; seed = 6'($urandom); tap_sel = 3'($urandom); pre_len = 8'($urandom);
  endtask

  task automatic run_enc(input logic [5:0] s, input logic [2:0] t, input logic [7:0] p);
    int n;
    bit seen_err;
    build_model(s, t, p);
    issue_start(s, t, p);
    check("busy_after_start", busy, 1);
    check("done_cleared", done, 0);
    n = 0;
    seen_err = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
      seen_err |= err;
      if (n == 30) begin start = 1'b1; seed = 6'd0; end
      if (n == 31) start = 1'b0;
    end
    start = 1'b0;
    check("done_latency", n, 66);
    check("no_err_midrun", seen_err, 0);
    check("busy_in_done", busy, 0);
    for (int i = 0; i < 64; i++) check($sformatf("ct[%0d]", i), mem[64 + i], exp_ct[i]);
  endtask

  initial begin
    int wc;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_err", err, 0);
    check("rst_raddr", raddr, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    @(negedge clk); rst_n = 1'b1;

    run_enc(6'h01, 3'd0, 8'd7);
    check("tp_mem64", mem[64], 8'h5e);
    check("tp_mem65", mem[65], 8'h5c);
    check("tp_mem66", mem[66], 8'h58);

    for (int i = 0; i < 5; i++) mem[i] = hello[i];
    run_enc(6'h2a, 3'd3, 8'd10);
    for (int i = 0; i < 5; i++)
      check($sformatf("decrypt_hello[%0d]", i), mem[64 + 10 + i] ^ {2'b00, key[10 + i]}, hello[i]);

    run_enc(6'($urandom_range(63, 1)), 3'($urandom_range(5)), 8'd3);
    for (int i = 0; i < 8; i++)
      check($sformatf("pre7_key[%0d]", i), (mem[64 + i] ^ {2'b00, key[i]}) == 8'h5f, (i < 7) || mem[0] == 8'h5f);
    run_enc(6'($urandom_range(63, 1)), 3'($urandom_range(5)), 8'd40);
    for (int i = 0; i < 13; i++)
      check($sformatf("pre12_key[%0d]", i), (mem[64 + i] ^ {2'b00, key[i]}) == 8'h5f, (i < 12) || mem[0] == 8'h5f);

    wc = wr_count;
    issue_start(6'h00, 3'd1, 8'd8);
    check("err_seed0", err, 1);
    check("done_kept_seed0", done, 1);
    @(posedge clk); #1;
    check("err_pulse_end", err, 0);
    check("busy_after_rej", busy, 0);
    issue_start(6'h15, 3'd6, 8'd8);
    check("err_tap6", err, 1);
    @(posedge clk); #1;
    check("err_tap6_end", err, 0);
    repeat (3) @(posedge clk);
    #1;
    check("no_write_rejected", wr_count, wc);
    check("idle_after_rej", busy, 0);

    for (int i = 64; i < 128; i++) mem[i] = 8'haa;
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    build_model(6'h2f, 3'd4, 8'd9);
    issue_start(6'h2f, 3'd4, 8'd9);
    begin
      int n = 0;
      while (!(wr_en && waddr == 8'd84) && n < 100) begin @(negedge clk); n++; end
      check("reach_idx20", n < 100, 1);
    end
    rst_n = 1'b0;
    #1;
    check("abort_wr_en", wr_en, 0);
    check("abort_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) check($sformatf("part_ct[%0d]", i), mem[64 + i], exp_ct[i]);
    for (int i = 85; i < 128; i++) check($sformatf("untouched[%0d]", i), mem[i], 8'haa);
    check("done_after_abort", done, 0);

    mem[0] = 8'h85;
    run_enc(6'h13, 3'd2, 8'd8);
`ifdef ENC_ASCII_FILTER_EN
    check("filter_byte", mem[64 + 8], 8'h20 ^ {2'b00, key[8]});
`else
    check("verbatim_byte", mem[64 + 8], 8'h85 ^ {2'b00, key[8]});
`endif

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
      run_enc(6'($urandom_range(63, 1)), 3'($urandom_range(5)), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
